// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge
//   Sits between the CPU's memory-mapped UART register and simple_uart, with
//   one FIFO per direction. The TX FIFO takes CPU writes, and a small drain
//   FSM feeds them to simple_uart's txdata/txgo handshake. The RX FIFO
//   captures every rxint byte, so slow polling does not drop characters.
//   The toplevel builds the read word from these outputs:
//   {rx_overrun, tx_overflow, cpu_rxvalid, cpu_txready, cpu_rxdata}.
//
// Ports
//   clk, reset        system clock; asynchronous active-low reset
//   cpu_txdata/txwr   byte and one-cycle push strobe into the TX FIFO
//   cpu_rxrd          one-cycle strobe; pops the head of the RX FIFO
//   cpu_clr           one-cycle strobe; clears both sticky error flags
//   cpu_rxdata        head of the RX FIFO (first-word fall-through)
//   cpu_rxvalid       RX FIFO not empty
//   cpu_txready       TX FIFO not full
//   rx_overrun        sticky; an RX byte was dropped because the RX FIFO was full
//   tx_overflow       sticky; a CPU write was dropped because the TX FIFO was full
//   tx_count/rx_count FIFO occupancy
//   uart_txdata/txgo  byte and one-cycle start pulse to simple_uart
//   uart_txready      simple_uart transmitter idle
//   uart_rxdata/rxint received byte and its one-cycle valid pulse
//   drain_state       current state of the TX drain FSM (debug)
//
// Handshake rules: a push (cpu_txwr, uart_rxint) or pop (cpu_rxrd, drain)
// takes effect only on a clock edge where the matching strobe is high and
// the FIFO can accept it, judged from the FIFO state before that edge. A
// refused push is dropped and sets its sticky flag. A refused pop is
// ignored. The strobes carry no back-pressure: a strobe held for N cycles
// is N requests.
module uart_fifo_bridge #(
    parameter int depth_log2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            cpu_txdata,
    input  logic                  cpu_txwr,
    input  logic                  cpu_rxrd,
    input  logic                  cpu_clr,
    output logic [7:0]            cpu_rxdata,
    output logic                  cpu_rxvalid,
    output logic                  cpu_txready,
    output logic                  rx_overrun,
    output logic                  tx_overflow,
    output logic [depth_log2:0]   tx_count,
    output logic [depth_log2:0]   rx_count,
    output logic [7:0]            uart_txdata,
    output logic                  uart_txgo,
    input  logic                  uart_txready,
    input  logic [7:0]            uart_rxdata,
    input  logic                  uart_rxint,
    output logic [1:0]            drain_state
);

    localparam int depth = 1 << depth_log2;
    localparam logic [depth_log2:0]   full_count = (depth_log2 + 1)'(depth);
    localparam logic [depth_log2:0]   cnt_one    = (depth_log2 + 1)'(1);
    localparam logic [depth_log2-1:0] ptr_one    = depth_log2'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2,
        WAIT  = 2'd3
    } drain_t;

    drain_t state, state_next;
    logic   guard_cnt, guard_cnt_next;

    logic [7:0]            tx_mem [depth];
    logic [7:0]            rx_mem [depth];
    logic [depth_log2-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;

    assign tx_full  = (tx_count == full_count);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == full_count);
    assign rx_empty = (rx_count == '0);

    // Full/empty tests use pre-edge occupancy, so a same-cycle pop never makes
    // room for a push, and a push into an empty FIFO is never popped at once.
    assign tx_push = cpu_txwr && !tx_full;
    assign tx_pop  = (state == IDLE) && !tx_empty && uart_txready;
    assign rx_push = uart_rxint && !rx_full;
    assign rx_pop  = cpu_rxrd && !rx_empty;

    assign cpu_rxdata  = rx_mem[rx_rptr];
    assign cpu_rxvalid = !rx_empty;
    assign cpu_txready = !tx_full;
    assign drain_state = state;

    // FIFO storage is not reset.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr] <= cpu_txdata;
        if (rx_push) rx_mem[rx_wptr] <= uart_rxdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wptr     <= '0;
            tx_rptr     <= '0;
            tx_count    <= '0;
            rx_wptr     <= '0;
            rx_rptr     <= '0;
            rx_count    <= '0;
            tx_overflow <= 1'b0;
            rx_overrun  <= 1'b0;
            uart_txdata <= 8'h00;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + ptr_one;
            if (tx_pop)  tx_rptr <= tx_rptr + ptr_one;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + cnt_one;
                2'b01:   tx_count <= tx_count - cnt_one;
                default: tx_count <= tx_count;
            endcase

            if (rx_push) rx_wptr <= rx_wptr + ptr_one;
            if (rx_pop)  rx_rptr <= rx_rptr + ptr_one;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + cnt_one;
                2'b01:   rx_count <= rx_count - cnt_one;
                default: rx_count <= rx_count;
            endcase

            // A new error in the same cycle as cpu_clr keeps the flag set.
            if (cpu_txwr && tx_full) tx_overflow <= 1'b1;
            else if (cpu_clr)        tx_overflow <= 1'b0;

            if (uart_rxint && rx_full) rx_overrun <= 1'b1;
            else if (cpu_clr)          rx_overrun <= 1'b0;

            // Loaded with the pop; stays stable through SEND/GUARD/WAIT.
            if (tx_pop) uart_txdata <= tx_mem[tx_rptr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            guard_cnt <= 1'b0;
        end else begin
            state     <= state_next;
            guard_cnt <= guard_cnt_next;
        end
    end

    // GUARD lasts two cycles so that simple_uart has time to drop txready
    // after txgo, before WAIT starts looking at it.
    always_comb begin
        state_next     = state;
        guard_cnt_next = guard_cnt;
        uart_txgo      = 1'b0;
        case (state)
            IDLE: begin
                if (tx_pop) state_next = SEND;
            end
            SEND: begin
                uart_txgo      = 1'b1;
                guard_cnt_next = 1'b0;
                state_next     = GUARD;
            end
            GUARD: begin
                if (guard_cnt) state_next = WAIT;
                else           guard_cnt_next = 1'b1;
            end
            WAIT: begin
                if (uart_txready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
Buffers bytes in both directions between the CPU's memory-mapped UART register (0xFFFFFFC0) and simple_uart. A TX FIFO accepts CPU writes and feeds simple_uart's txdata/txgo handshake. An RX FIFO captures every rxint byte, so slow CPU polling no longer drops characters. The CPU-side read word keeps the existing layout: bit9 = rx byte available, bit8 = tx can accept, bits[7:0] = rx data.

Parameters:
depth_log2, 4, log2 of each FIFO depth; 4 gives 16 entries per direction.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cpu_txdata  in  8  byte to transmit
cpu_txwr  in  1  one-cycle strobe; push cpu_txdata into TX FIFO
cpu_rxrd  in  1  one-cycle strobe; pop head of RX FIFO
cpu_clr  in  1  one-cycle strobe; clear sticky error flags
cpu_rxdata  out  8  head of RX FIFO (first-word fall-through)
cpu_rxvalid  out  1  RX FIFO not empty
cpu_txready  out  1  TX FIFO not full
rx_overrun  out  1  sticky; an RX byte was dropped because the RX FIFO was full
tx_overflow  out  1  sticky; a CPU write was dropped because the TX FIFO was full
tx_count  out  depth_log2+1  TX FIFO occupancy
rx_count  out  depth_log2+1  RX FIFO occupancy
uart_txdata  out  8  byte to simple_uart
uart_txgo  out  1  one-cycle transmit start pulse to simple_uart
uart_txready  in  1  simple_uart transmitter idle
uart_rxdata  in  8  received byte from simple_uart
uart_rxint  in  1  one-cycle pulse; uart_rxdata is valid

Behaviour:
- Reset (reset=0, asynchronous) clears the following:
  - FIFO pointers and counts go to 0.
  - uart_txgo=0, uart_txdata=0, rx_overrun=0, tx_overflow=0, drain FSM in IDLE.
  - Resulting outputs: cpu_rxvalid=0, cpu_txready=1.
  - FIFO contents are not reset.
  - Reset asserted mid-transmit aborts the handshake immediately; the byte in flight is lost.
- FIFOs: circular buffers with separate read/write pointers of depth_log2 bits and a count of depth_log2+1 bits.
  - Pointers wrap modulo 2^depth_log2.
  - full = (count == 2^depth_log2); empty = (count == 0).
- TX push: on cpu_txwr with !full, store the byte at the write pointer, increment the write pointer and count.
  - On cpu_txwr with full, drop the byte, set tx_overflow, and leave the FIFO unchanged.
- RX push: on uart_rxint with !full, store uart_rxdata and increment.
  - On uart_rxint with full, drop the byte and set rx_overrun.
  - A pop in the same cycle does NOT make room; the full test uses pre-cycle state.
- RX pop: on cpu_rxrd with !empty, advance the read pointer and decrement the count.
  - cpu_rxrd on empty is ignored.
  - cpu_rxdata is combinational from the read pointer; it is valid while cpu_rxvalid=1 and undefined otherwise.
- Simultaneous push and pop on a non-full, non-empty FIFO: both take effect and the count is unchanged.
  - On an empty FIFO, a simultaneous push and pop does the push only.
- cpu_clr clears both sticky flags. If a new error occurs in the same cycle as cpu_clr, the flag stays set (set wins).
- TX drain FSM states: IDLE, SEND, GUARD, WAIT.
  - IDLE: when TX FIFO !empty and uart_txready=1, load uart_txdata from the head and pop the TX FIFO in that same cycle; go to SEND.
  - SEND: uart_txgo=1 for exactly this one cycle; go to GUARD.
  - GUARD: hold for 2 cycles (covers simple_uart dropping txready after txgo); go to WAIT.
  - WAIT: when uart_txready=1, go to IDLE.
  - Outside SEND, uart_txgo=0. uart_txdata stays stable from SEND until the next load.
- Latency:
  - First byte written into an idle, empty TX FIFO with uart_txready=1: cpu_txwr at cycle N, pop/load at N+1, uart_txgo high at N+2.
  - Back-to-back bytes: minimum of 5 cycles between txgo pulses, plus the UART frame time.
- A TX pop and a CPU push in the same cycle follow the same rules as the RX FIFO.
- Status word the toplevel drives onto mem_read: {rx_overrun, tx_overflow, cpu_rxvalid, cpu_txready, cpu_rxdata}; bits[9:0] match the existing register layout.

Test Plan:
- Reset, then check idle outputs -> cpu_rxvalid=0, cpu_txready=1, tx_count=0, rx_count=0, uart_txgo=0, both flags 0.
- Write 0x41, 0x42, 0x43 back-to-back with uart_txready modelled as low for 20 cycles after each txgo -> three single-cycle txgo pulses carrying 0x41, 0x42, 0x43 in order; the first txgo occurs 2 cycles after the first write; tx_count returns to 0.
- With depth_log2=4, hold uart_txready=0 and write 17 bytes -> tx_count=16, cpu_txready=0, tx_overflow=1, and the 17th byte is never transmitted; cpu_clr then drops tx_overflow to 0.
- Pulse uart_rxint 16 times with data 0x00..0x0F, then once with 0xAA, with no reads -> rx_count=16, rx_overrun=1; 16 reads return 0x00..0x0F in order, then cpu_rxvalid=0.
- At rx_count=5, pulse uart_rxint (0x55) and cpu_rxrd in the same cycle -> rx_count stays 5, the old head is popped, and 0x55 lands at the tail; then 20 pointer wraps run with no data corruption.
- Assert reset while the FSM is in GUARD with 4 bytes queued -> tx_count=0, FSM in IDLE, no further txgo after reset is released.
